// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op code constants OP_MUL .. OP_RSV
//   - FSM state encoding (2 bits)
//   - small op-class helper functions
package muldiv_pkg;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_REMU  = 3'd3;
    localparam logic [2:0] OP_MULH  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_REM   = 3'd6;
    localparam logic [2:0] OP_RSV   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Division-class ops: the ones that use the restoring-subtract loop
    // and the divide-by-zero rule.
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_REMU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return (op == OP_REMU) || (op == OP_REM);
    endfunction

    // Multiply ops returning the upper half of the product.
    function automatic logic is_hi(input logic [2:0] op);
        return (op == OP_MULHU) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle of the multiply/divide unit.
//   request : in_valid, in_ready, op[2:0], a, b
//   response: out_valid, out_ready, res, div_zero
//   master = requester (execute stage), slave = muldiv_seq.
interface muldiv_if #(
    parameter int DATA_LEN = 32
) ();
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          op;
    logic [DATA_LEN-1:0] a;
    logic [DATA_LEN-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] res;
    logic                div_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, div_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, div_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide loop.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i/o  : 2*DATA_LEN accumulator. Multiply: {partial product, multiplier}.
//              Divide: low half holds dividend bits shifting out / quotient
//              bits shifting in; upper half passes through.
//   mcand_i  : multiplicand (multiply) or divisor (divide)
//   rem_i/o  : DATA_LEN+1 bit partial remainder (passes through on multiply)
module muldiv_step #(
    parameter int DATA_LEN = 32
) (
    input  logic                    is_div_i,
    input  logic [2*DATA_LEN-1:0]   acc_i,
    input  logic [DATA_LEN-1:0]     mcand_i,
    input  logic [DATA_LEN:0]       rem_i,
    output logic [2*DATA_LEN-1:0]   acc_o,
    output logic [DATA_LEN:0]       rem_o
);

    logic [DATA_LEN:0]   sum;
    logic [DATA_LEN+1:0] shl;
    logic                ge;

    always_comb begin
        // Multiply: conditional add into the upper half, keeping the carry
        // so the right shift does not lose it.
        sum = {1'b0, acc_i[2*DATA_LEN-1:DATA_LEN]} + {1'b0, mcand_i};

        // Divide: shift next dividend MSB into the remainder, trial-subtract.
        shl = {rem_i, acc_i[DATA_LEN-1]};
        ge  = (shl >= {2'b00, mcand_i});

        if (is_div_i) begin
            acc_o = {acc_i[2*DATA_LEN-1:DATA_LEN], acc_i[DATA_LEN-2:0], ge};
            rem_o = ge ? (shl[DATA_LEN:0] - {1'b0, mcand_i}) : shl[DATA_LEN:0];
        end else begin
            rem_o = rem_i;
            if (acc_i[0]) acc_o = {sum, acc_i[DATA_LEN-1:1]};
            else          acc_o = {1'b0, acc_i[2*DATA_LEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit, one result bit per cycle.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : muldiv_if.slave (in_valid/in_ready/op/a/b request,
//              out_valid/out_ready/res/div_zero response)
// Ops 0..3 unsigned, 4..6 signed, 7 reserved (res=0, immediate).
// Optional build macro MULDIV_SIGNED_EN: when defined, ops 4/5/6 are signed
// (magnitude datapath plus operand/result negators); when undefined they
// alias ops 1/2/3 and no negation logic exists.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = $clog2(DATA_LEN) + 1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [2*DATA_LEN-1:0]   acc_q, acc_d;
    logic [DATA_LEN:0]       rem_q, rem_d;
    logic [DATA_LEN-1:0]     mcand_q, mcand_d;
    logic [DATA_LEN-1:0]     res_q, res_d;
    logic                    dz_q, dz_d;
`ifdef MULDIV_SIGNED_EN
    logic                    neg_q, neg_d;
    logic                    a_neg, b_neg;
`endif

    logic [2:0]              op_eff;
    logic [DATA_LEN-1:0]     a_mag, b_mag;
    logic [2*DATA_LEN-1:0]   step_acc;
    logic [DATA_LEN:0]       step_rem;
    logic [2*DATA_LEN-1:0]   raw;
    logic [DATA_LEN-1:0]     fix_res;

    muldiv_step #(.DATA_LEN(DATA_LEN)) u_step (
        .is_div_i (is_div(op_q)),
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .rem_i    (rem_q),
        .acc_o    (step_acc),
        .rem_o    (step_rem)
    );

    // Operand pre-processing at accept: op aliasing and magnitudes.
    always_comb begin
        op_eff = bus.op;
        a_mag  = bus.a;
        b_mag  = bus.b;
`ifdef MULDIV_SIGNED_EN
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        if (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) begin
            a_neg = bus.a[DATA_LEN-1];
            b_neg = bus.b[DATA_LEN-1];
        end
        if (a_neg) a_mag = -bus.a;
        if (b_neg) b_mag = -bus.b;
`else
        unique case (bus.op)
            OP_MULH: op_eff = OP_MULHU;
            OP_DIV:  op_eff = OP_DIVU;
            OP_REM:  op_eff = OP_REMU;
            default: op_eff = bus.op;
        endcase
`endif
    end

    // Result selection and sign fix-up on the final iteration. Quotient and
    // remainder are zero-extended into the 2N-wide value so a single negator
    // serves both the product and the divide results.
    always_comb begin
        if (is_div(op_q))
            raw = {{DATA_LEN{1'b0}}, is_rem(op_q) ? step_rem[DATA_LEN-1:0] : step_acc[DATA_LEN-1:0]};
        else
            raw = step_acc;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) raw = -raw;
`endif
        fix_res = is_hi(op_q) ? raw[2*DATA_LEN-1:DATA_LEN] : raw[DATA_LEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        dz_d    = dz_q;
`ifdef MULDIV_SIGNED_EN
        neg_d   = neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d = op_eff;
                    dz_d = 1'b0;
                    if (op_eff == OP_RSV) begin
                        state_d = S_DONE;
                        res_d   = '0;
                    end else if (is_div(op_eff) && (bus.b == '0)) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                        res_d   = is_rem(op_eff) ? bus.a : '1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(DATA_LEN);
                        rem_d   = '0;
                        if (is_div(op_eff)) begin
                            acc_d   = {{DATA_LEN{1'b0}}, a_mag};
                            mcand_d = b_mag;
                        end else begin
                            acc_d   = {{DATA_LEN{1'b0}}, b_mag};
                            mcand_d = a_mag;
                        end
`ifdef MULDIV_SIGNED_EN
                        // Remainder follows the dividend; product/quotient
                        // follow the sign difference.
                        neg_d = is_rem(op_eff) ? a_neg : (a_neg ^ b_neg);
`endif
                    end
                end
            end
            S_BUSY: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = fix_res;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.res       = res_q;
        bus.div_zero  = dz_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (DATA_LEN=32).
// Signed-op vectors are compiled when MULDIV_SIGNED_EN is defined; otherwise
// the aliasing vectors are used.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if #(.DATA_LEN(N)) bus ();

    muldiv_seq #(.DATA_LEN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Issue one request; lat counts edges from the accept edge (inclusive)
    // to the first edge after which out_valid is seen high.
    task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit pop, output logic [N-1:0] r, output logic dz, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout op=%0d: out_valid=%b required 1", op, bus.out_valid);
        end
        r  = bus.res;
        dz = bus.div_zero;
        if (pop) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.res !== 32'h0)      begin n_fail++; $display("FAIL reset_res got=%h exp=0", bus.res); end
        n_cmp++; if (bus.div_zero !== 1'b0)  begin n_fail++; $display("FAIL reset_div_zero got=%b exp=0", bus.div_zero); end
    endtask

    task automatic test_mul();
        logic [N-1:0] r; logic dz; int lat;
        run_op(OP_MUL, 32'h0001_0001, 32'h0001_0001, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0002_0001) begin n_fail++; $display("FAIL mul_res got=%h exp=00020001", r); end
        n_cmp++; if (lat !== 33)          begin n_fail++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        n_cmp++; if (dz !== 1'b0)         begin n_fail++; $display("FAIL mul_dz got=%b exp=0", dz); end
        run_op(OP_MULHU, 32'h0001_0001, 32'h0001_0001, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mulhu_res got=%h exp=00000001", r); end
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_max_lo got=%h exp=00000001", r); end
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max got=%h exp=fffffffe", r); end
    endtask

    task automatic test_div();
        logic [N-1:0] r; logic dz; int lat;
        run_op(OP_DIVU, 32'd100, 32'd7, 1, r, dz, lat);
        n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_res got=%h exp=0000000e", r); end
        n_cmp++; if (lat !== 33)   begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        run_op(OP_REMU, 32'd100, 32'd7, 1, r, dz, lat);
        n_cmp++; if (r !== 32'd2)  begin n_fail++; $display("FAIL remu_res got=%h exp=00000002", r); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by1 got=%h exp=ffffffff", r); end
        run_op(OP_DIVU, 32'd5, 32'd0, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_dz_res got=%h exp=ffffffff", r); end
        n_cmp++; if (dz !== 1'b1)  begin n_fail++; $display("FAIL divu_dz_flag got=%b exp=1", dz); end
        n_cmp++; if (lat !== 1)    begin n_fail++; $display("FAIL divu_dz_latency got=%0d exp=1", lat); end
        run_op(OP_REMU, 32'd5, 32'd0, 1, r, dz, lat);
        n_cmp++; if (r !== 32'd5)  begin n_fail++; $display("FAIL remu_dz_res got=%h exp=00000005", r); end
        n_cmp++; if (dz !== 1'b1)  begin n_fail++; $display("FAIL remu_dz_flag got=%b exp=1", dz); end
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        logic [N-1:0] r; logic dz; int lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0)         begin n_fail++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0)         begin n_fail++; $display("FAIL mulh_m1m1 got=%h exp=00000000", r); end
        run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_m2x3 got=%h exp=ffffffff", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_dz_res got=%h exp=fffffff9", r); end
        n_cmp++; if (dz !== 1'b1)         begin n_fail++; $display("FAIL rem_dz_flag got=%b exp=1", dz); end
    endtask
`else
    task automatic test_alias();
        logic [N-1:0] r; logic dz; int lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL alias_div got=%h exp=7ffffffc", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL alias_rem got=%h exp=00000001", r); end
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL alias_mulh got=%h exp=fffffffe", r); end
        run_op(OP_DIV, 32'd9, 32'd0, 1, r, dz, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL alias_div_dz got=%h exp=ffffffff", r); end
        n_cmp++; if (dz !== 1'b1)         begin n_fail++; $display("FAIL alias_div_dz_flag got=%b exp=1", dz); end
    endtask
`endif

    task automatic test_reserved();
        logic [N-1:0] r; logic dz; int lat;
        run_op(OP_MUL, 32'd6, 32'd7, 1, r, dz, lat);   // leaves a nonzero result behind
        run_op(OP_RSV, 32'h1234_5678, 32'h0, 1, r, dz, lat);
        n_cmp++; if (r !== 32'h0)  begin n_fail++; $display("FAIL rsv_res got=%h exp=00000000", r); end
        n_cmp++; if (lat !== 1)    begin n_fail++; $display("FAIL rsv_latency got=%0d exp=1", lat); end
        n_cmp++; if (dz !== 1'b0)  begin n_fail++; $display("FAIL rsv_dz got=%b exp=0", dz); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] r; logic dz; int lat; int bad;
        run_op(OP_MUL, 32'd6, 32'd7, 0, r, dz, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.res !== 32'd42 || bus.div_zero !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable bad_cycles=%0d exp=0 res=%h", bad, bus.res); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL pop_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pop_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        // Stray request and response-ready pulses while busy.
        bus.op = OP_MUL; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (bus.res !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_res got=%h exp=0000000e", bus.res); end
        n_cmp++; if (lat !== 33)         begin n_fail++; $display("FAIL busy_ignore_latency got=%0d exp=33", lat); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] r; logic dz; int lat; int seen;
        bus.op = OP_MUL; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (16) @(posedge clk);    // counter now at 16
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.res !== 32'h0)      begin n_fail++; $display("FAIL midrst_res got=%h exp=00000000", bus.res); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
        run_op(OP_MUL, 32'd3, 32'd4, 1, r, dz, lat);
        n_cmp++; if (r !== 32'd12) begin n_fail++; $display("FAIL midrst_mul got=%h exp=0000000c", r); end
        n_cmp++; if (lat !== 33)   begin n_fail++; $display("FAIL midrst_latency got=%0d exp=33", lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_mul();
        test_div();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`else
        test_alias();
`endif
        test_reserved();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
